resp_sig_analyzer: RTL and testbench

//   Response-side checker for gate-level benchmark netlists (c1908 and similar) built from the cell library.

---
 rtl/resp_sig_analyzer.sv | 107 ++++++++++
 tb/tb_resp_sig_analyzer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/resp_sig_analyzer.sv
// MISR-based response compactor: folds NUM_PAT response vectors into a signature
// and compares it against a golden value once the run completes.
module resp_sig_analyzer #(
    parameter int unsigned          DATA_W  = 25,
    parameter int unsigned          SIG_W   = 32,
    parameter logic [SIG_W-1:0]     POLY    = 32'h04C11DB7,
    parameter logic [SIG_W-1:0]     SEED    = 32'hFFFFFFFF,
    parameter int unsigned          NUM_PAT = 1024,
    localparam int unsigned         CNT_W   = $clog2(NUM_PAT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              resp_valid,
    input  logic [DATA_W-1:0] resp_data,
    input  logic [SIG_W-1:0]  golden_sig,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [SIG_W-1:0]  signature,
    output logic [CNT_W-1:0]  pat_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CHECK = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_PAT - 1);

    state_e             state_q, state_d;
    logic [SIG_W-1:0]   sig_q, sig_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;

    logic               accept;
    logic [SIG_W-1:0]   misr_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sig_q   <= SEED;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    // Vectors are only taken in RUN, so the count can never pass NUM_PAT.
    assign accept    = (state_q == ST_RUN) && resp_valid;
    assign misr_next = {sig_q[SIG_W-2:0], 1'b0}
                     ^ (sig_q[SIG_W-1] ? POLY : '0)
                     ^ SIG_W'(resp_data);

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        pass_d  = pass_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    sig_d   = SEED;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    sig_d = misr_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_IDX) begin
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                pass_d  = (sig_q == golden_sig);
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        busy      = (state_q != ST_IDLE);
        done      = done_q;
        pass      = pass_q;
        signature = sig_q;
        pat_count = cnt_q;
    end

endmodule

// File: tb/tb_resp_sig_analyzer.sv
// Directed and randomized checks of resp_sig_analyzer on three parameterisations.
module tb_resp_sig_analyzer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance A: DATA_W=4, SIG_W=8, POLY=1D, SEED=00, NUM_PAT=2
    logic       a_start, a_valid;
    logic [3:0] a_data;
    logic [7:0] a_gold;
    logic       a_busy, a_done, a_pass;
    logic [7:0] a_sig;
    logic [1:0] a_cnt;

    // Instance B: SEED=80, NUM_PAT=1
    logic       b_start, b_valid;
    logic [3:0] b_data;
    logic [7:0] b_gold;
    logic       b_busy, b_done, b_pass;
    logic [7:0] b_sig;
    logic       b_cnt;

    // Instance C: default widths/polynomial/seed, NUM_PAT=20
    logic        c_start, c_valid;
    logic [24:0] c_data;
    logic [31:0] c_gold;
    logic        c_busy, c_done, c_pass;
    logic [31:0] c_sig;
    logic [4:0]  c_cnt;

    resp_sig_analyzer #(.DATA_W(4), .SIG_W(8), .POLY(8'h1D), .SEED(8'h00), .NUM_PAT(2)) u_a (
        .clk(clk), .rst(rst), .start(a_start), .resp_valid(a_valid), .resp_data(a_data),
        .golden_sig(a_gold), .busy(a_busy), .done(a_done), .pass(a_pass),
        .signature(a_sig), .pat_count(a_cnt)
    );

    resp_sig_analyzer #(.DATA_W(4), .SIG_W(8), .POLY(8'h1D), .SEED(8'h80), .NUM_PAT(1)) u_b (
        .clk(clk), .rst(rst), .start(b_start), .resp_valid(b_valid), .resp_data(b_data),
        .golden_sig(b_gold), .busy(b_busy), .done(b_done), .pass(b_pass),
        .signature(b_sig), .pat_count(b_cnt)
    );

    resp_sig_analyzer #(.NUM_PAT(20)) u_c (
        .clk(clk), .rst(rst), .start(c_start), .resp_valid(c_valid), .resp_data(c_data),
        .golden_sig(c_gold), .busy(c_busy), .done(c_done), .pass(c_pass),
        .signature(c_sig), .pat_count(c_cnt)
    );

    // One compaction step on a w-bit register, as polynomial arithmetic over GF(2).
    function automatic logic [63:0] misr(input logic [63:0] s, input logic [63:0] d,
                                         input int w, input logic [63:0] poly);
        logic [63:0] mask;
        logic [63:0] r;
        mask = (64'd1 << w) - 64'd1;
        r = (s << 1) & mask;
        if (s[w-1]) r = r ^ poly;
        return (r ^ d) & mask;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_begin();
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        check("a_start_busy", a_busy, 1);
        check("a_start_done_clr", a_done, 0);
        check("a_start_cnt", a_cnt, 0);
        check("a_start_sig", a_sig, 8'h00);
    endtask

    task automatic a_vec(input logic [3:0] d);
        a_valid = 1'b1;
        a_data  = d;
        tick();
        a_valid = 1'b0;
        a_data  = 4'h0;
    endtask

    initial begin
        logic [3:0]  qa[$];
        logic [24:0] qc[$];
        logic [63:0] exp_sig;
        logic        exp_pass;
        int          nv;

        rst = 1'b1;
        {a_start, a_valid, a_data, a_gold} = '0;
        {b_start, b_valid, b_data, b_gold} = '0;
        {c_start, c_valid, c_data, c_gold} = '0;
        tick();
        tick();
        check("rst_a_busy", a_busy, 0);
        check("rst_a_done", a_done, 0);
        check("rst_a_pass", a_pass, 0);
        check("rst_a_sig", a_sig, 8'h00);
        check("rst_a_cnt", a_cnt, 0);
        check("rst_b_sig", b_sig, 8'h80);
        check("rst_c_sig", c_sig, 32'hFFFFFFFF);
        check("rst_c_cnt", c_cnt, 0);
        rst = 1'b0;
        tick();

        // Case 1: back-to-back vectors, matching golden
        a_gold = 8'h03;
        a_begin();
        a_vec(4'h3);
        check("c1_sig1", a_sig, 8'h03);
        check("c1_cnt1", a_cnt, 1);
        a_vec(4'h5);
        check("c1_sig2", a_sig, 8'h03);
        check("c1_cnt2", a_cnt, 2);
        check("c1_busy_check", a_busy, 1);
        check("c1_done_early", a_done, 0);
        tick();
        check("c1_done", a_done, 1);
        check("c1_pass", a_pass, 1);
        check("c1_busy_idle", a_busy, 0);
        check("c1_cnt_hold", a_cnt, 2);

        // Case 2: wrong golden
        a_gold = 8'h04;
        a_begin();
        a_vec(4'h3);
        a_vec(4'h5);
        tick();
        check("c2_done", a_done, 1);
        check("c2_pass", a_pass, 0);
        check("c2_sig", a_sig, 8'h03);

        // Case 3: gaps with junk data on the bus
        a_gold = 8'h03;
        a_begin();
        a_vec(4'h3);
        for (int i = 0; i < 3; i++) begin
            a_data = 4'hF;
            tick();
            check("c3_gap_busy", a_busy, 1);
            check("c3_gap_sig", a_sig, 8'h03);
            check("c3_gap_cnt", a_cnt, 1);
        end
        a_vec(4'h5);
        tick();
        check("c3_done", a_done, 1);
        check("c3_pass", a_pass, 1);
        check("c3_sig", a_sig, 8'h03);

        // Case 4: feedback path
        b_gold  = 8'h1D;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        check("c4_busy", b_busy, 1);
        b_valid = 1'b1;
        b_data  = 4'h0;
        tick();
        b_valid = 1'b0;
        check("c4_sig", b_sig, 8'h1D);
        check("c4_cnt", b_cnt, 1);
        tick();
        check("c4_done", b_done, 1);
        check("c4_pass", b_pass, 1);

        // Case 5: start in RUN/CHECK and vectors after CHECK are ignored
        a_gold = 8'h03;
        a_begin();
        a_vec(4'h3);
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        check("c5_run_start_cnt", a_cnt, 1);
        check("c5_run_start_sig", a_sig, 8'h03);
        a_valid = 1'b1;
        a_data  = 4'h5;
        tick();
        a_data  = 4'hF;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        tick();
        tick();
        a_valid = 1'b0;
        check("c5_cnt", a_cnt, 2);
        check("c5_sig", a_sig, 8'h03);
        check("c5_done", a_done, 1);
        check("c5_pass", a_pass, 1);
        check("c5_busy", a_busy, 0);

        // Case 6: reset mid-run on A and C
        a_begin();
        c_start = 1'b1;
        tick();
        c_start = 1'b0;
        a_vec(4'h3);
        c_valid = 1'b1;
        c_data  = 25'h1ABCDEF;
        tick();
        c_valid = 1'b0;
        check("c6_c_cnt_pre", c_cnt, 1);
        rst = 1'b1;
        #1;
        check("c6_a_busy", a_busy, 0);
        check("c6_a_done", a_done, 0);
        check("c6_a_sig", a_sig, 8'h00);
        check("c6_a_cnt", a_cnt, 0);
        check("c6_c_busy", c_busy, 0);
        check("c6_c_sig", c_sig, 32'hFFFFFFFF);
        check("c6_c_cnt", c_cnt, 0);
        tick();
        check("c6_a_no_done", a_done, 0);
        rst = 1'b0;
        tick();
        a_begin();
        a_vec(4'h3);
        a_vec(4'h5);
        tick();
        check("c6_rerun_done", a_done, 1);
        check("c6_rerun_pass", a_pass, 1);

        // Randomized runs on A with gaps, junk data and stray starts
        for (int r = 0; r < 20; r++) begin
            qa.delete();
            exp_sig = 64'h00;
            for (int k = 0; k < 2; k++) begin
                qa.push_back(4'($urandom_range(0, 15)));
                exp_sig = misr(exp_sig, 64'(qa[k]), 8, 64'h1D);
            end
            if ($urandom_range(0, 1) == 1) a_gold = exp_sig[7:0];
            else a_gold = 8'($urandom_range(0, 255));
            exp_pass = (a_gold == exp_sig[7:0]);
            a_begin();
            foreach (qa[k]) begin
                nv = $urandom_range(0, 3);
                for (int g = 0; g < nv; g++) begin
                    a_data  = 4'($urandom_range(0, 15));
                    a_start = 1'($urandom_range(0, 1));
                    tick();
                    a_start = 1'b0;
                end
                a_vec(qa[k]);
            end
            a_valid = 1'($urandom_range(0, 1));
            a_data  = 4'($urandom_range(0, 15));
            tick();
            a_valid = 1'b0;
            check("rand_a_sig", a_sig, exp_sig);
            check("rand_a_cnt", a_cnt, 2);
            check("rand_a_done", a_done, 1);
            check("rand_a_pass", a_pass, exp_pass);
        end

        // Randomized runs on C at full width
        for (int r = 0; r < 4; r++) begin
            qc.delete();
            exp_sig = 64'hFFFFFFFF;
            c_start = 1'b1;
            tick();
            c_start = 1'b0;
            check("rand_c_seed", c_sig, 32'hFFFFFFFF);
            for (int k = 0; k < 20; k++) begin
                nv = $urandom_range(0, 2);
                for (int g = 0; g < nv; g++) begin
                    c_data = 25'($urandom);
                    tick();
                end
                qc.push_back(25'($urandom));
                exp_sig = misr(exp_sig, 64'(qc[k]), 32, 64'h04C11DB7);
                c_valid = 1'b1;
                c_data  = qc[k];
                tick();
                c_valid = 1'b0;
                check("rand_c_sig", c_sig, exp_sig);
                check("rand_c_cnt", c_cnt, 64'(k + 1));
            end
            c_gold = (r % 2 == 0) ? exp_sig[31:0] : (exp_sig[31:0] ^ 32'h0000_0100);
            tick();
            check("rand_c_done", c_done, 1);
            check("rand_c_pass", c_pass, (r % 2 == 0) ? 1 : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
